// File: rtl/dk_anim_sequencer.sv
// -----------------------------------------------------------------------------
// dk_anim_sequencer
//   Per-sprite animation sequencer. It turns key state and ground contact into
//   an animation state (IDLE / WALK / JUMP / THROW) and a frame index. All
//   registers advance only on frame_tick (one pulse per vsync). Every other
//   cycle holds.
//
//   Optional feature macro: DK_ANIM_THROW_EN
//     defined   -> THROW state, key_throw handling and the candy_frame counter
//                  are compiled in.
//     undefined -> key_throw is ignored and candy_frame is tied to 0.
//
// Ports
//   Clk          system clock
//   Reset        synchronous, active-high
//   frame_tick   one-Clk pulse per video frame
//   key_left/key_right/key_jump/key_throw   held-key levels
//   on_ground    ground contact from physics
//   motion       0 IdleR,1 IdleL,2 WalkR,3 WalkL,4 JumpR,5 JumpL,6 Throw
//   framenum     frame index within the current state
//   candy_frame  candy projectile frame index
//   facing_left  current facing
//   busy         high in JUMP / THROW (non-interruptible)
// -----------------------------------------------------------------------------
module dk_anim_sequencer #(
    parameter int unsigned TICKS_PER_FRAME = 4,
    parameter int unsigned IDLE_FRAMES     = 10,
    parameter int unsigned WALK_FRAMES     = 20,
    parameter int unsigned JUMP_FRAMES     = 20,
    parameter int unsigned THROW_FRAMES    = 10,
    parameter int unsigned CANDY_FRAMES    = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_jump,
    input  logic        key_throw,
    input  logic        on_ground,
    output logic [3:0]  motion,
    output logic [18:0] framenum,
    output logic [18:0] candy_frame,
    output logic        facing_left,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_JUMP  = 2'd2,
        ST_THROW = 2'd3
    } state_e;

    localparam int unsigned DIV_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICKS_PER_FRAME - 1);
    localparam logic [18:0] IDLE_LAST  = 19'(IDLE_FRAMES - 1);
    localparam logic [18:0] WALK_LAST  = 19'(WALK_FRAMES - 1);
    localparam logic [18:0] JUMP_LAST  = 19'(JUMP_FRAMES - 1);
    localparam logic [18:0] THROW_LAST = 19'(THROW_FRAMES - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [18:0]      fn_q, fn_d;
    logic             facing_q, facing_d;
    logic [3:0]       motion_q, motion_d;
    logic             busy_q, busy_d;
    logic             adv;
    logic             walk_req;
    logic             throw_req;

`ifdef DK_ANIM_THROW_EN
    localparam logic [18:0] CANDY_LAST = 19'(CANDY_FRAMES - 1);
    logic [18:0] candy_q, candy_d;
    assign throw_req   = key_throw;
    assign candy_frame = candy_q;
`else
    logic throw_unused;
    assign throw_unused = key_throw;
    assign throw_req    = 1'b0;
    assign candy_frame  = '0;
`endif

    assign adv      = (div_q == DIV_MAX);
    assign walk_req = key_left ^ key_right;   // both or neither held -> no walk

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        fn_d     = fn_q;
        facing_d = facing_q;
`ifdef DK_ANIM_THROW_EN
        candy_d  = candy_q;
`endif
        if (frame_tick) begin
            div_d = adv ? '0 : div_q + 1'b1;

            case (state_q)
                ST_IDLE, ST_WALK: begin
                    if (throw_req)                  state_d = ST_THROW;
                    else if (key_jump && on_ground) state_d = ST_JUMP;
                    else if (walk_req) begin
                        state_d  = ST_WALK;
                        facing_d = key_left;
                    end
                    else                            state_d = ST_IDLE;
                end
                ST_JUMP: begin
                    if (walk_req) facing_d = key_left;
                    if (adv && fn_q == JUMP_LAST && on_ground) state_d = ST_IDLE;
                end
                ST_THROW: begin
                    if (adv && fn_q == THROW_LAST) state_d = ST_IDLE;
                end
            endcase

            if (state_d != state_q) begin
                fn_d  = '0;
                div_d = '0;
`ifdef DK_ANIM_THROW_EN
                if (state_d == ST_THROW) candy_d = '0;
`endif
            end
            else if (adv) begin
                case (state_q)
                    ST_IDLE:  fn_d = (fn_q == IDLE_LAST) ? '0 : fn_q + 1'b1;
                    ST_WALK:  fn_d = (fn_q == WALK_LAST) ? '0 : fn_q + 1'b1;
                    // last jump frame holds until landing
                    ST_JUMP:  fn_d = (fn_q == JUMP_LAST) ? fn_q : fn_q + 1'b1;
                    ST_THROW: begin
                        fn_d = fn_q + 1'b1;
`ifdef DK_ANIM_THROW_EN
                        candy_d = (candy_q == CANDY_LAST) ? '0 : candy_q + 1'b1;
`endif
                    end
                endcase
            end
        end

        // outputs are registered from the next-state values
        case (state_d)
            ST_IDLE:  motion_d = {3'd0, facing_d};
            ST_WALK:  motion_d = {3'd1, facing_d};
            ST_JUMP:  motion_d = {3'd2, facing_d};
            ST_THROW: motion_d = 4'd6;
            default:  motion_d = 4'd0;
        endcase
        busy_d = (state_d == ST_JUMP) || (state_d == ST_THROW);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            fn_q     <= '0;
            facing_q <= 1'b0;
            motion_q <= '0;
            busy_q   <= 1'b0;
`ifdef DK_ANIM_THROW_EN
            candy_q  <= '0;
`endif
        end
        else begin
            state_q  <= state_d;
            div_q    <= div_d;
            fn_q     <= fn_d;
            facing_q <= facing_d;
            motion_q <= motion_d;
            busy_q   <= busy_d;
`ifdef DK_ANIM_THROW_EN
            candy_q  <= candy_d;
`endif
        end
    end

    assign motion      = motion_q;
    assign framenum    = fn_q;
    assign facing_left = facing_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dk_anim_sequencer.sv
module tb_dk_anim_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, frame_tick;
    logic        key_left, key_right, key_jump, key_throw, on_ground;
    logic [3:0]  motion;
    logic [18:0] framenum, candy_frame;
    logic        facing_left, busy;

    dk_anim_sequencer dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
        .key_throw(key_throw), .on_ground(on_ground),
        .motion(motion), .framenum(framenum), .candy_frame(candy_frame),
        .facing_left(facing_left), .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       nm;
        logic        l, r, j, t, g;
        int          n;
        logic [3:0]  m;
        logic [18:0] fn;
        logic        fl, bsy;
        logic [18:0] cf;
        logic        cfchk;
    } vec_t;

    typedef struct {
        string       nm;
        logic [3:0]  m;
        logic [18:0] fn;
        logic        fl, bsy;
        logic [18:0] cf;
        logic        cfchk;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(string nm, logic l, logic r, logic j, logic t, logic g,
                                int n, logic [3:0] m, logic [18:0] fn, logic fl,
                                logic bsy, logic [18:0] cf, logic cfchk);
        vec_t v;
        v.nm = nm; v.l = l; v.r = r; v.j = j; v.t = t; v.g = g; v.n = n;
        v.m = m; v.fn = fn; v.fl = fl; v.bsy = bsy; v.cf = cf; v.cfchk = cfchk;
        tbl.push_back(v);
    endfunction

    task automatic push_exp(string nm, logic [3:0] m, logic [18:0] fn, logic fl,
                            logic bsy, logic [18:0] cf, logic cfchk);
        exp_t e;
        e.nm = nm; e.m = m; e.fn = fn; e.fl = fl; e.bsy = bsy; e.cf = cf; e.cfchk = cfchk;
        sb.push_back(e);
    endtask

    task automatic drive(logic l, logic r, logic j, logic t, logic g);
        key_left = l; key_right = r; key_jump = j; key_throw = t; on_ground = g;
    endtask

    // n back-to-back ticks; n==0 idles a few cycles to show that state holds
    task automatic ticks(int n);
        if (n == 0) repeat (3) @(negedge Clk);
        else begin
            frame_tick = 1'b1;
            repeat (n) @(negedge Clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic check();
        exp_t e;
        bit   bad;
        n_vec++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard-empty: no expected record");
            n_bad++;
        end
        else begin
            e   = sb.pop_front();
            bad = 0;
            if (motion !== e.m) begin
                $display("FAIL %s motion got %0d want %0d", e.nm, motion, e.m); bad = 1;
            end
            if (framenum !== e.fn) begin
                $display("FAIL %s framenum got %0d want %0d", e.nm, framenum, e.fn); bad = 1;
            end
            if (facing_left !== e.fl) begin
                $display("FAIL %s facing got %0b want %0b", e.nm, facing_left, e.fl); bad = 1;
            end
            if (busy !== e.bsy) begin
                $display("FAIL %s busy got %0b want %0b", e.nm, busy, e.bsy); bad = 1;
            end
            if (e.cfchk && candy_frame !== e.cf) begin
                $display("FAIL %s candy got %0d want %0d", e.nm, candy_frame, e.cf); bad = 1;
            end
            if (bad) n_bad++;
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            drive(tbl[i].l, tbl[i].r, tbl[i].j, tbl[i].t, tbl[i].g);
            push_exp(tbl[i].nm, tbl[i].m, tbl[i].fn, tbl[i].fl, tbl[i].bsy, tbl[i].cf, tbl[i].cfchk);
            ticks(tbl[i].n);
            check();
        end
        tbl.delete();
    endtask

    // reset with frame_tick and keys active: reset must win
    task automatic reset_check(string nm);
        Reset = 1'b1; frame_tick = 1'b1;
        drive(1, 0, 1, 1, 1);
        push_exp(nm, 4'd0, 19'd0, 1'b0, 1'b0, 19'd0, 1'b1);
        @(negedge Clk);
        check();
        Reset = 1'b0; frame_tick = 1'b0;
        drive(0, 0, 0, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; frame_tick = 1'b0;
        drive(0, 0, 0, 0, 1);
        repeat (2) @(negedge Clk);
        reset_check("reset");

        //   name       l r j t g  n   m  fn  fl b  cf chk
        add("idle3",    0,0,0,0,1, 3,  0, 0,  0,0, 0,1);
        add("idle4",    0,0,0,0,1, 1,  0, 1,  0,0, 0,1);
        add("hold",     1,0,0,0,1, 0,  0, 1,  0,0, 0,1);
        add("idle39",   0,0,0,0,1, 35, 0, 9,  0,0, 0,1);
        add("idle40",   0,0,0,0,1, 1,  0, 0,  0,0, 0,1);
        add("idle44",   0,0,0,0,1, 4,  0, 1,  0,0, 0,1);
        add("walkL",    1,0,0,0,1, 1,  3, 0,  1,0, 0,1);
        add("walkL4",   1,0,0,0,1, 4,  3, 1,  1,0, 0,1);
        add("relL",     0,0,0,0,1, 1,  1, 0,  1,0, 0,1);
        add("walkR",    0,1,0,0,1, 1,  2, 0,  0,0, 0,1);
        add("turnL",    1,0,0,0,1, 1,  3, 0,  1,0, 0,1);
        add("turnL3",   1,0,0,0,1, 3,  3, 1,  1,0, 0,1);
        add("both",     1,1,0,0,1, 1,  1, 0,  1,0, 0,1);
        add("both4",    1,1,0,0,1, 4,  1, 1,  1,0, 0,1);
        add("walkR2",   0,1,0,0,1, 1,  2, 0,  0,0, 0,1);
        add("jump",     0,0,1,0,1, 1,  4, 0,  0,1, 0,1);
        add("air3",     0,0,0,0,0, 3,  4, 0,  0,1, 0,1);
        add("air4",     0,0,0,0,0, 1,  4, 1,  0,1, 0,1);
        add("air76",    0,0,0,0,0, 72, 4, 19, 0,1, 0,1);
        add("air100",   0,0,0,0,0, 24, 4, 19, 0,1, 0,1);
        add("airL",     1,0,0,0,0, 1,  5, 19, 1,1, 0,1);
        add("land2",    0,0,0,0,1, 2,  5, 19, 1,1, 0,1);
        add("land",     0,0,0,0,1, 1,  1, 0,  1,0, 0,1);
        add("jumpAir",  0,0,1,0,0, 1,  1, 0,  1,0, 0,1);
        run_table();

        // mid-jump reset
        drive(0, 0, 1, 0, 1);
        push_exp("rjump", 4'd5, 19'd0, 1'b1, 1'b1, 19'd0, 1'b1);
        ticks(1); check();
        drive(0, 0, 0, 0, 0);
        push_exp("rjump5", 4'd5, 19'd5, 1'b1, 1'b1, 19'd0, 1'b1);
        ticks(20); check();
        reset_check("midjump-reset");

`ifdef DK_ANIM_THROW_EN
        add("throw",    0,0,0,1,1, 1,  6, 0,  0,1, 0,1);
        add("thr28",    1,0,1,0,1, 28, 6, 7,  0,1, 7,1);
        add("thr32",    1,0,1,0,1, 4,  6, 8,  0,1, 0,1);
        add("thr36",    0,1,1,0,1, 4,  6, 9,  0,1, 1,1);
        add("thr39",    1,0,1,0,1, 3,  6, 9,  0,1, 1,1);
        add("thrEnd",   1,0,1,0,1, 1,  0, 0,  0,0, 0,0);
`else
        add("nothrow",  0,0,0,1,1, 1,  0, 0,  0,0, 0,1);
        add("nothrow4", 0,0,0,1,1, 3,  0, 1,  0,0, 0,1);
        add("thrWalk",  1,0,0,1,1, 1,  3, 0,  1,0, 0,1);
`endif
        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
